// File: rtl/tdp18k_fifo_rd_stream_if.sv
// Bus bundle between the TDP18K FIFO read port, the read-stream adapter and the stream sink.
// Signal prefixes are from the adapter's point of view; master = adapter, slave = FIFO/sink side.
interface tdp18k_fifo_rd_stream_if #(
  parameter int DATA_WIDTH = 18
);
  logic                  i_empty;
  logic                  i_epo;
  logic                  i_underrun;
  logic                  o_ren;
  logic [17:0]           i_rdata;
  logic                  o_m_valid;
  logic                  i_m_ready;
  logic [DATA_WIDTH-1:0] o_m_data;

  modport master (
    input  i_empty, i_epo, i_underrun, i_rdata, i_m_ready,
    output o_ren, o_m_valid, o_m_data
  );

  modport slave (
    output i_empty, i_epo, i_underrun, i_rdata, i_m_ready,
    input  o_ren, o_m_valid, o_m_data
  );
endinterface

// File: rtl/tdp18k_fifo_rd_stream.sv
// Read-side adapter for the TDP18K FIFO: issues REN and turns the 1-cycle read latency
// into a first-word-fall-through valid/ready stream through a 2-entry head/tail buffer.
module tdp18k_fifo_rd_stream #(
  parameter int DATA_WIDTH = 18,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_flush_n,
  tdp18k_fifo_rd_stream_if.master  bus,
  output logic [CNT_WIDTH-1:0]     o_rd_cnt,
  output logic                     o_err
);

  // State encoding equals the number of buffered words.
  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_ren_q;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic [CNT_WIDTH-1:0]  r_rd_cnt;
  logic                  r_err;

  logic                  w_pop;
  logic                  w_push;
  logic                  w_ren;
  logic                  w_empty_after_pop;
  logic                  w_overflow;
  logic [1:0]            w_occ;
  logic [2:0]            w_pending;
  logic [2:0]            w_limit;
  logic [DATA_WIDTH-1:0] w_rdata_map;

  generate
    if (DATA_WIDTH == 9) begin : g_map9
      assign w_rdata_map = {bus.i_rdata[16], bus.i_rdata[7:0]};
    end else begin : g_map18
      assign w_rdata_map = bus.i_rdata[DATA_WIDTH-1:0];
    end
  endgenerate

  assign w_occ             = r_state;
  assign w_pop             = (r_state != S0) & bus.i_m_ready;
  assign w_push            = r_ren_q;
  assign w_pending         = {1'b0, w_occ} + {2'b00, r_ren_q};
  assign w_limit           = 3'd2 + {2'b00, w_pop};
  assign w_empty_after_pop = (r_state == S0) | ((r_state == S1) & w_pop);
  assign w_overflow        = w_push & (r_state == S2) & ~w_pop;

  // Flags lag one read: with a read in flight, EPO means the FIFO is really empty.
  assign w_ren = i_rst_n & i_flush_n & ~bus.i_empty & ~(r_ren_q & bus.i_epo)
               & (w_pending < w_limit);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S0;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S0: if (w_push) w_state_next = S1;
      S1: begin
        if (w_push & ~w_pop) begin
          w_state_next = S2;
        end else if (w_pop & ~w_push) begin
          w_state_next = S0;
        end
      end
      S2: if (w_pop & ~w_push) w_state_next = S1;
      default: w_state_next = S0;
    endcase
    if (!i_flush_n) begin
      w_state_next = S0;
    end
  end

  always_comb begin
    bus.o_ren     = w_ren;
    bus.o_m_valid = (r_state != S0);
    bus.o_m_data  = r_head;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ren_q  <= 1'b0;
      r_head   <= '0;
      r_tail   <= '0;
      r_rd_cnt <= '0;
      r_err    <= 1'b0;
    end else if (!i_flush_n) begin
      r_ren_q  <= 1'b0;
      r_rd_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_ren_q <= w_ren;
      if (w_pop) begin
        r_rd_cnt <= r_rd_cnt + CNT_WIDTH'(1);
      end
      if (bus.i_underrun | w_overflow) begin
        r_err <= 1'b1;
      end
      // Tail advances first; a simultaneous push then lands behind it, preserving order.
      if (w_pop & (r_state == S2)) begin
        r_head <= r_tail;
      end
      if (w_push) begin
        if (w_empty_after_pop) begin
          r_head <= w_rdata_map;
        end else begin
          r_tail <= w_rdata_map;
        end
      end
    end
  end

  assign o_rd_cnt = r_rd_cnt;
  assign o_err    = r_err;

endmodule

// File: tb/tb_tdp18k_fifo_rd_stream.sv
// Bench for tdp18k_fifo_rd_stream: a queue-based FIFO with lagging flags feeds the adapter,
// and a word-level model of the buffered stream is compared against the outputs every cycle.
module tb_tdp18k_fifo_rd_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        flush_n;
  logic [15:0] rd_cnt;
  logic        err;

  tdp18k_fifo_rd_stream_if #(.DATA_WIDTH(18)) bus ();

  tdp18k_fifo_rd_stream #(.DATA_WIDTH(18), .CNT_WIDTH(16)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_flush_n (flush_n),
    .bus       (bus),
    .o_rd_cnt  (rd_cnt),
    .o_err     (err)
  );

  // Narrow instance: 9-bit mapping and a 4-bit counter to reach the wrap quickly.
  logic       flush9_n = 1'b1;
  logic [3:0] rd_cnt9;
  logic       err9;
  tdp18k_fifo_rd_stream_if #(.DATA_WIDTH(9)) bus9 ();

  tdp18k_fifo_rd_stream #(.DATA_WIDTH(9), .CNT_WIDTH(4)) dut9 (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_flush_n (flush9_n),
    .bus       (bus9),
    .o_rd_cnt  (rd_cnt9),
    .o_err     (err9)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // FIFO model: flags are registered from the count before this edge's read/write.
  logic [17:0] fifo_q[$];
  logic        f_empty = 1'b1;
  logic        f_epo   = 1'b0;
  logic [17:0] f_rdata = '0;
  logic        wr_req  = 1'b0;
  logic [17:0] wr_data = '0;
  int          f_sz;

  assign bus.i_empty = f_empty;
  assign bus.i_epo   = f_epo;
  assign bus.i_rdata = f_rdata;

  always @(posedge clk) begin
    f_sz = fifo_q.size();
    if (!flush_n) begin
      fifo_q.delete();
      f_empty <= 1'b1;
      f_epo   <= 1'b0;
    end else begin
      f_empty <= (f_sz == 0);
      f_epo   <= (f_sz == 1);
      if (bus.o_ren) begin
        if (f_sz > 0) f_rdata <= fifo_q.pop_front();
        else          f_rdata <= 18'h3FFFF;
      end
      if (wr_req) fifo_q.push_back(wr_data);
    end
  end

  // Stream model: words delivered but not yet taken, plus one possible read in flight.
  logic [17:0] m_buf[$];
  bit          m_infl = 1'b0;
  logic [17:0] m_infl_word = '0;
  int unsigned m_cnt = 0;
  bit          m_err = 1'b0;
  bit          e_valid;
  bit          e_pop;
  bit          e_ren;
  int          cyc = 0;
  int          ren_cyc[$];
  int          pop_cyc[$];
  logic [17:0] pop_w[$];

  always @(negedge clk) begin
    cyc++;
    if (bus.o_ren) ren_cyc.push_back(cyc);
    if (bus.o_m_valid && bus.i_m_ready) begin
      pop_w.push_back(bus.o_m_data);
      pop_cyc.push_back(cyc);
    end
    if (!rst_n) begin
      chk("rst_ren", {31'b0, bus.o_ren}, 0);
      chk("rst_valid", {31'b0, bus.o_m_valid}, 0);
      chk("rst_data", {14'b0, bus.o_m_data}, 0);
      chk("rst_cnt", {16'b0, rd_cnt}, 0);
      chk("rst_err", {31'b0, err}, 0);
      m_buf.delete();
      m_infl = 1'b0;
      m_cnt  = 0;
      m_err  = 1'b0;
    end else begin
      e_valid = (m_buf.size() != 0);
      chk("valid", {31'b0, bus.o_m_valid}, {31'b0, e_valid});
      if (e_valid) chk("data", {14'b0, bus.o_m_data}, {14'b0, m_buf[0]});
      chk("rd_cnt", {16'b0, rd_cnt}, {16'b0, m_cnt[15:0]});
      chk("err", {31'b0, err}, {31'b0, m_err});
      e_pop = e_valid && bus.i_m_ready;
      e_ren = flush_n && !f_empty && !(m_infl && f_epo)
              && ((m_buf.size() + int'(m_infl)) < (2 + int'(e_pop)));
      chk("ren", {31'b0, bus.o_ren}, {31'b0, e_ren});
      if (bus.o_ren) chk("ren_nonempty", {31'b0, fifo_q.size() != 0}, 1);
      if (!flush_n) begin
        m_buf.delete();
        m_infl = 1'b0;
        m_cnt  = 0;
        m_err  = 1'b0;
      end else begin
        if (bus.i_underrun) m_err = 1'b1;
        if (e_pop) begin
          void'(m_buf.pop_front());
          m_cnt++;
        end
        if (m_infl) m_buf.push_back(m_infl_word);
        m_infl = e_ren;
        if (e_ren) m_infl_word = (fifo_q.size() > 0) ? fifo_q[0] : 18'h3FFFF;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_words(input logic [17:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_req  = 1'b1;
      wr_data = base + 18'(i);
      tick(1);
    end
    wr_req = 1'b0;
  endtask

  task automatic clear_logs();
    ren_cyc.delete();
    pop_cyc.delete();
    pop_w.delete();
  endtask

  // Narrow-instance checks: FIFO never empty, constant read data, sink always ready.
  int np9 = 0;
  assign bus9.i_empty    = 1'b0;
  assign bus9.i_epo      = 1'b0;
  assign bus9.i_underrun = 1'b0;
  assign bus9.i_m_ready  = 1'b1;
  logic [17:0] rdata9 = 18'h100AB;
  assign bus9.i_rdata = rdata9;

  initial begin
    wait (rst_n === 1'b1);
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      chk("t4_cnt", {28'b0, rd_cnt9}, np9 % 16);
      if (np9 == 16) chk("t4_wrap_zero", {28'b0, rd_cnt9}, 0);
      if (bus9.o_m_valid) begin
        chk("t4_map_1ab", {23'b0, bus9.o_m_data}, 32'h1AB);
        np9++;
      end
    end
    chk("t4_enough_pops", {31'b0, np9 > 17}, 1);
    rdata9 = 18'h2FF54;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t4_map_054", {23'b0, bus9.o_m_data}, 32'h054);
    end
  end

  int n_after;

  initial begin
    rst_n = 1'b0;
    flush_n = 1'b1;
    bus.i_m_ready = 1'b1;
    bus.i_underrun = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // 1: four words, sink ready
    clear_logs();
    write_words(18'h00001, 4);
    tick(12);
    chk("t1_ren_pulses", ren_cyc.size(), 4);
    chk("t1_pops", pop_w.size(), 4);
    if (ren_cyc.size() == 4 && pop_w.size() == 4) begin
      chk("t1_ren_consec", ren_cyc[3] - ren_cyc[0], 3);
      chk("t1_pop_consec", pop_cyc[3] - pop_cyc[0], 3);
      chk("t1_latency", pop_cyc[0] - ren_cyc[0], 2);
      for (int i = 0; i < 4; i++) chk("t1_word", {14'b0, pop_w[i]}, i + 1);
    end
    chk("t1_rd_cnt", {16'b0, rd_cnt}, 4);

    // 2: single word with stale flags
    clear_logs();
    write_words(18'h2A5A5, 1);
    tick(10);
    chk("t2_ren_pulses", ren_cyc.size(), 1);
    chk("t2_pops", pop_w.size(), 1);
    if (pop_w.size() == 1) chk("t2_word", {14'b0, pop_w[0]}, 32'h2A5A5);
    chk("t2_err", {31'b0, err}, 0);

    // 3: backpressure then release
    clear_logs();
    bus.i_m_ready = 1'b0;
    write_words(18'h3A000, 10);
    tick(8);
    chk("t3_ren_held", ren_cyc.size(), 2);
    chk("t3_valid_held", {31'b0, bus.o_m_valid}, 1);
    chk("t3_data_held", {14'b0, bus.o_m_data}, 32'h3A000);
    bus.i_m_ready = 1'b1;
    tick(20);
    chk("t3_pops", pop_w.size(), 10);
    chk("t3_ren_total", ren_cyc.size(), 10);
    if (pop_w.size() == 10) begin
      for (int i = 0; i < 10; i++) chk("t3_order", {14'b0, pop_w[i]}, 32'h3A000 + i);
      chk("t3_no_gaps", pop_cyc[9] - pop_cyc[0], 9);
    end

    // 5a: flush with a full buffer
    bus.i_m_ready = 1'b0;
    write_words(18'h15000, 12);
    tick(3);
    chk("t5_full", {31'b0, bus.o_m_valid}, 1);
    flush_n = 1'b0;
    tick(1);
    flush_n = 1'b1;
    chk("t5a_valid", {31'b0, bus.o_m_valid}, 0);
    chk("t5a_cnt", {16'b0, rd_cnt}, 0);

    // 5b: flush mid-stream with a read in flight
    write_words(18'h16000, 12);
    bus.i_m_ready = 1'b1;
    tick(3);
    chk("t5b_in_flight", {31'b0, dut.r_ren_q}, 1);
    flush_n = 1'b0;
    tick(1);
    flush_n = 1'b1;
    n_after = pop_w.size();
    chk("t5b_valid", {31'b0, bus.o_m_valid}, 0);
    chk("t5b_cnt", {16'b0, rd_cnt}, 0);
    tick(6);
    chk("t5b_discarded", pop_w.size(), n_after);

    // 6: asynchronous reset mid-stream, then underrun
    bus.i_m_ready = 1'b0;
    write_words(18'h17000, 6);
    bus.i_m_ready = 1'b1;
    tick(1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_ren", {31'b0, bus.o_ren}, 0);
    chk("t6_valid", {31'b0, bus.o_m_valid}, 0);
    chk("t6_data", {14'b0, bus.o_m_data}, 0);
    chk("t6_cnt", {16'b0, rd_cnt}, 0);
    tick(2);
    rst_n = 1'b1;
    tick(8);
    bus.i_underrun = 1'b1;
    tick(1);
    bus.i_underrun = 1'b0;
    chk("t6_err_set", {31'b0, err}, 1);
    tick(3);
    chk("t6_err_sticky", {31'b0, err}, 1);
    flush_n = 1'b0;
    tick(1);
    flush_n = 1'b1;
    chk("t6_err_clr", {31'b0, err}, 0);

    // Random traffic against the model
    for (int i = 0; i < 2500; i++) begin
      wr_req         = ($urandom % 2) == 0;
      wr_data        = 18'($urandom);
      bus.i_m_ready  = ($urandom % 10) < 7;
      flush_n        = ($urandom % 150) != 0;
      bus.i_underrun = ($urandom % 300) == 0;
      tick(1);
    end
    wr_req = 1'b0;
    flush_n = 1'b1;
    bus.i_underrun = 1'b0;
    bus.i_m_ready = 1'b1;
    tick(10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
